// File: rtl/alu_op_sequencer_if.sv
// Command, result and ALU-drive bundle of the ALU op sequencer.
// With ALU_SEQ_NZP_EN defined the bundle also carries the n/z/p result flags.
interface alu_op_sequencer_if #(parameter int WIDTH = 16);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_k;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
`ifdef ALU_SEQ_NZP_EN
    logic             res_n;
    logic             res_z;
    logic             res_p;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_k, res_valid, res_data, res_err,
        output res_n, res_z, res_p
    );
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_k, res_valid, res_data, res_err,
        input  res_n, res_z, res_p
    );
`else
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_k, res_valid, res_data, res_err
    );
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_k, res_valid, res_data, res_err
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer expanding SUB/NEG/OR into native ALU ops (ADD/AND/NOT/PASS).
// Optional ALU_SEQ_NZP_EN adds registered n/z/p flags alongside res_data.
//
// state | meaning
// IDLE  | ALU parked, accepting a command
// EXEC  | one micro-step per cycle, step selects the ALU drive
// DONE  | result held until the consumer takes it
module alu_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus,
    output logic               busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] D_R  = 2'd0;
    localparam logic [1:0] D_T0 = 2'd1;
    localparam logic [1:0] D_T1 = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       step;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, t0, t1;
    logic [1:0]       dst;

    assign bus.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);

    // ALU drive and destination decode; anything outside EXEC parks the ALU on PASS 0
    always_comb begin
        bus.alu_a = '0;
        bus.alu_b = '0;
        bus.alu_k = 2'b11;
        dst       = D_R;
        if (state == S_EXEC) begin
            case (op_q)
                3'b000: begin bus.alu_k = 2'b00; bus.alu_a = a_q; bus.alu_b = b_q; end
                3'b001: begin bus.alu_k = 2'b01; bus.alu_a = a_q; bus.alu_b = b_q; end
                3'b010: begin bus.alu_k = 2'b10; bus.alu_a = a_q; end
                3'b011: begin bus.alu_k = 2'b11; bus.alu_a = a_q; end
                3'b100: begin
                    case (step)
                        2'd0:    begin bus.alu_k = 2'b10; bus.alu_a = b_q; dst = D_T0; end
                        2'd1:    begin bus.alu_k = 2'b00; bus.alu_a = t0; bus.alu_b = ONE; dst = D_T0; end
                        default: begin bus.alu_k = 2'b00; bus.alu_a = a_q; bus.alu_b = t0; end
                    endcase
                end
                3'b101: begin
                    case (step)
                        2'd0:    begin bus.alu_k = 2'b10; bus.alu_a = a_q; dst = D_T0; end
                        default: begin bus.alu_k = 2'b00; bus.alu_a = t0; bus.alu_b = ONE; end
                    endcase
                end
                3'b110: begin
                    // De Morgan: A|B = ~(~A & ~B)
                    case (step)
                        2'd0:    begin bus.alu_k = 2'b10; bus.alu_a = a_q; dst = D_T0; end
                        2'd1:    begin bus.alu_k = 2'b10; bus.alu_a = b_q; dst = D_T1; end
                        2'd2:    begin bus.alu_k = 2'b01; bus.alu_a = t0; bus.alu_b = t1; dst = D_T0; end
                        default: begin bus.alu_k = 2'b10; bus.alu_a = t0; end
                    endcase
                end
                default: begin bus.alu_k = 2'b11; bus.alu_a = a_q; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            step          <= 2'd0;
            op_q          <= 3'b000;
            a_q           <= '0;
            b_q           <= '0;
            t0            <= '0;
            t1            <= '0;
            bus.res_data  <= '0;
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
`ifdef ALU_SEQ_NZP_EN
            bus.res_n     <= 1'b0;
            bus.res_z     <= 1'b0;
            bus.res_p     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q  <= bus.cmd_op;
                        a_q   <= bus.cmd_a;
                        b_q   <= bus.cmd_b;
                        step  <= 2'd0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (dst)
                        D_T0: t0 <= bus.alu_result;
                        D_T1: t1 <= bus.alu_result;
                        default: ;
                    endcase
                    if (dst == D_R) begin
                        bus.res_data  <= bus.alu_result;
                        bus.res_err   <= (op_q == 3'b111);
                        bus.res_valid <= 1'b1;
`ifdef ALU_SEQ_NZP_EN
                        bus.res_n     <= bus.alu_result[WIDTH-1];
                        bus.res_z     <= (bus.alu_result == '0);
                        bus.res_p     <= !bus.alu_result[WIDTH-1] && (bus.alu_result != '0);
`endif
                        state         <= S_DONE;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
